// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the banked RAM.
package ram_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 9;
    localparam int BANK_BITS_DEF = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: a byte-enabled write port and two asynchronous read ports.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = ADDR_W_DEF - BANK_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [IDX_W-1:0]      raddr_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic [IDX_W-1:0]      raddr_b,
    output logic [DATA_W-1:0]     rdata_b
);

    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**IDX_W];

    // Storage carries no reset; the owner zeroes it through the write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/ram_banked.sv
// Banked dual-read RAM with byte-enabled writes and a hardware clear sequence.
// Define RAM_BANKED_BYPASS_EN to forward same-cycle write data to the read ports.
module ram_banked
    import ram_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BANK_BITS = BANK_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     d_in,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  rd_en_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     d_out_a,
    output logic [DATA_W-1:0]     d_out_b,
    output logic                  valid_a,
    output logic                  valid_b,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int IDX_W = ADDR_W - BANK_BITS;
    localparam int NBANK = 2**BANK_BITS;
    localparam int NBYTE = DATA_W / 8;

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;

    assign busy = (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + IDX_W'(1);
                    if (&clr_cnt) state <= IDLE;
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    logic [BANK_BITS-1:0] wr_bank, rd_bank_a, rd_bank_b;
    logic [IDX_W-1:0]     wr_idx, rd_idx_a, rd_idx_b;

    assign wr_bank   = wr_addr[ADDR_W-1 -: BANK_BITS];
    assign rd_bank_a = rd_addr_a[ADDR_W-1 -: BANK_BITS];
    assign rd_bank_b = rd_addr_b[ADDR_W-1 -: BANK_BITS];
    assign wr_idx    = wr_addr[IDX_W-1:0];
    assign rd_idx_a  = rd_addr_a[IDX_W-1:0];
    assign rd_idx_b  = rd_addr_b[IDX_W-1:0];

    logic [NBANK-1:0]  bank_we;
    logic [IDX_W-1:0]  bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic [NBYTE-1:0]  bank_be;

    // During a clear every bank writes zero at the counter index, overriding user writes.
    always_comb begin
        bank_we    = '0;
        bank_waddr = wr_idx;
        bank_wdata = d_in;
        bank_be    = be;
        if (busy) begin
            bank_we    = '1;
            bank_waddr = clr_cnt;
            bank_wdata = '0;
            bank_be    = '1;
        end else if (wr) begin
            bank_we    = NBANK'(1) << wr_bank;
        end
    end

    logic [DATA_W-1:0] bank_rd_a [NBANK];
    logic [DATA_W-1:0] bank_rd_b [NBANK];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        ram_bank #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .waddr   (bank_waddr),
            .wdata   (bank_wdata),
            .be      (bank_be),
            .raddr_a (rd_idx_a),
            .rdata_a (bank_rd_a[b]),
            .raddr_b (rd_idx_b),
            .rdata_b (bank_rd_b[b])
        );
    end

    logic [DATA_W-1:0] rd_word_a, rd_word_b;

`ifdef RAM_BANKED_BYPASS_EN
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBYTE-1:0]  en
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NBYTE; i++) begin
            if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    logic fwd_a, fwd_b;
    assign fwd_a     = wr && !busy && (wr_addr == rd_addr_a);
    assign fwd_b     = wr && !busy && (wr_addr == rd_addr_b);
    assign rd_word_a = fwd_a ? merge_bytes(bank_rd_a[rd_bank_a], d_in, be) : bank_rd_a[rd_bank_a];
    assign rd_word_b = fwd_b ? merge_bytes(bank_rd_b[rd_bank_b], d_in, be) : bank_rd_b[rd_bank_b];
`else
    assign rd_word_a = bank_rd_a[rd_bank_a];
    assign rd_word_b = bank_rd_b[rd_bank_b];
`endif

    logic rd_go_a, rd_go_b;
    assign rd_go_a = rd_en_a && !busy;
    assign rd_go_b = rd_en_b && !busy;

    // Stage p1: registered read data and its valid pulse
    logic [DATA_W-1:0] d_out_a_p1, d_out_b_p1;
    logic              vld_a_p1, vld_b_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_a_p1 <= '0;
            d_out_b_p1 <= '0;
            vld_a_p1   <= 1'b0;
            vld_b_p1   <= 1'b0;
        end else begin
            vld_a_p1 <= rd_go_a;
            vld_b_p1 <= rd_go_b;
            if (rd_go_a) d_out_a_p1 <= rd_word_a;
            if (rd_go_b) d_out_b_p1 <= rd_word_b;
        end
    end

    assign d_out_a = d_out_a_p1;
    assign d_out_b = d_out_b_p1;
    assign valid_a = vld_a_p1;
    assign valid_b = vld_b_p1;

endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked against an array-based reference model.
module tb_ram_banked;

    localparam int DW = 16;
    localparam int AW = 9;
`ifdef RAM_BANKED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] d_in;
    logic [1:0]    be;
    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] d_out_a, d_out_b;
    logic          valid_a, valid_b;
    logic          clr_req;
    logic          busy;

    always #5 clk = ~clk;

    ram_banked dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .be        (be),
        .rd_en_a   (rd_en_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .valid_a   (valid_a),
        .valid_b   (valid_b),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    logic [DW-1:0] model [2**AW];
    logic [AW-1:0] hot [4];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [1:0] en);
        return {en[1] ? new_w[15:8] : old_w[15:8], en[0] ? new_w[7:0] : old_w[7:0]};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        wr = 1'b1; wr_addr = a; d_in = d; be = b;
        tick();
        wr = 1'b0;
        model[a] = merge(model[a], d, b);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        rd_en_a = 1'b1; rd_addr_a = aa;
        rd_en_b = 1'b1; rd_addr_b = ab;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        chk({tag, "_vld_a"}, valid_a, 1);
        chk({tag, "_dat_a"}, d_out_a, model[aa]);
        chk({tag, "_vld_b"}, valid_b, 1);
        chk({tag, "_dat_b"}, d_out_b, model[ab]);
        tick();
        chk({tag, "_novld_a"}, valid_a, 0);
        chk({tag, "_hold_a"}, d_out_a, model[aa]);
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 1) return hot[$urandom_range(0, 3)];
        return AW'($urandom_range(0, 2**AW - 1));
    endfunction

    initial begin
        int n, n0;
        logic [DW-1:0] exp_a, exp_b;
        hot[0] = 9'h000; hot[1] = 9'h03F; hot[2] = 9'h040; hot[3] = 9'h1FF;
        reset = 1'b1; wr = 1'b0; wr_addr = '0; d_in = '0; be = '0;
        rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 1);
        chk("rst_dout_a", d_out_a, 0);
        chk("rst_dout_b", d_out_b, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_valid_b", valid_b, 0);

        // Initial clear after reset release
        reset = 1'b0;
        chk("post_rst_busy", busy, 1);
        wait_busy_low(n);
        chk("init_clear_cycles", n, 64);
        clear_model();
        do_read("zero_0_63", 9'h000, 9'h03F);
        chk("zero_0", d_out_a, 16'h0000);
        do_read("zero_64_511", 9'h040, 9'h1FF);
        chk("zero_511", d_out_b, 16'h0000);

        // Full-word write then dual read
        do_write(9'h1A5, 16'hBEEF, 2'b11);
        do_read("beef", 9'h1A5, 9'h1A5);
        chk("beef_a", d_out_a, 16'hBEEF);
        chk("beef_b", d_out_b, 16'hBEEF);

        // Byte-enable merge
        do_write(9'h010, 16'h1234, 2'b11);
        do_write(9'h010, 16'hAB00, 2'b10);
        do_read("bytemerge", 9'h010, 9'h1A5);
        chk("bytemerge_val", d_out_a, 16'hAB34);

        // Same-cycle write and read
        do_write(9'h0FF, 16'h1111, 2'b11);
        wr = 1'b1; wr_addr = 9'h0FF; d_in = 16'h5555; be = 2'b11;
        rd_en_a = 1'b1; rd_addr_a = 9'h0FF;
        tick();
        wr = 1'b0; rd_en_a = 1'b0;
        chk("collide_vld", valid_a, 1);
        chk("collide_dat", d_out_a, BYP ? 16'h5555 : 16'h1111);
        model[9'h0FF] = 16'h5555;
        do_read("after_collide", 9'h0FF, 9'h0FF);

        // Clear request; writes and reads ignored while busy
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy", busy, 1);
        wr = 1'b1; wr_addr = 9'h1C2; d_in = 16'hFFFF; be = 2'b11;
        rd_en_a = 1'b1; rd_addr_a = 9'h1A5; rd_en_b = 1'b1; rd_addr_b = 9'h010;
        n0 = 0;
        repeat (5) begin
            tick();
            n0++;
            chk("busy_vld_a", valid_a, 0);
            chk("busy_vld_b", valid_b, 0);
        end
        wr = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        wait_busy_low(n);
        chk("clr_cycles", n0 + n, 64);
        clear_model();
        do_read("clr_zero1", 9'h1C2, 9'h1A5);
        do_read("clr_zero2", 9'h010, 9'h0FF);

        // Randomized traffic against the reference model
        exp_a = d_out_a; exp_b = d_out_b;
        for (int it = 0; it < 150; it++) begin
            logic          w, ea, eb;
            logic [AW-1:0] wa, ra, rb;
            logic [DW-1:0] d;
            logic [1:0]    b;
            w  = 1'($urandom_range(0, 1));
            ea = 1'($urandom_range(0, 1));
            eb = 1'($urandom_range(0, 1));
            wa = pick(); ra = pick(); rb = pick();
            d  = DW'($urandom);
            b  = 2'($urandom_range(0, 3));
            if (ea) exp_a = (w && wa == ra && BYP) ? merge(model[ra], d, b) : model[ra];
            if (eb) exp_b = (w && wa == rb && BYP) ? merge(model[rb], d, b) : model[rb];
            wr = w; wr_addr = wa; d_in = d; be = b;
            rd_en_a = ea; rd_addr_a = ra; rd_en_b = eb; rd_addr_b = rb;
            tick();
            if (w) model[wa] = merge(model[wa], d, b);
            chk("rnd_vld_a", valid_a, ea);
            chk("rnd_dat_a", d_out_a, exp_a);
            chk("rnd_vld_b", valid_b, eb);
            chk("rnd_dat_b", d_out_b, exp_b);
        end
        wr = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;

        // Reset ten cycles into a clear
        do_write(9'h020, 16'h7E7E, 2'b11);
        do_read("pre_clr", 9'h020, 9'h020);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        chk("midclr_hold_a", d_out_a, 16'h7E7E);
        reset = 1'b1;
        #1;
        chk("midrst_dout_a", d_out_a, 0);
        chk("midrst_dout_b", d_out_b, 0);
        chk("midrst_vld_a", valid_a, 0);
        chk("midrst_busy", busy, 1);
        tick();
        reset = 1'b0;
        wait_busy_low(n);
        chk("midrst_clear_cycles", n, 64);
        clear_model();
        do_read("midrst_zero", 9'h020, 9'h1FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_banked.md
RAM_BANKED -- requirements
Module: ram_banked

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 9: address width; depth = 2**ADDR_W words.
REQ-003 Parameter BANK_BITS, default 3: number of banks = 2**BANK_BITS; SHALL be less than ADDR_W.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port wr, input, 1: write strobe.
REQ-007 Port wr_addr, input, ADDR_W: write address.
REQ-008 Port d_in, input, DATA_W: write data.
REQ-009 Port be, input, DATA_W/8: byte enables for the write; bit i covers d_in[8i+7:8i].
REQ-010 Ports rd_en_a and rd_en_b, input, 1 each: read requests for ports A and B.
REQ-011 Ports rd_addr_a and rd_addr_b, input, ADDR_W each: read addresses.
REQ-012 Ports d_out_a and d_out_b, output, DATA_W each: registered read data.
REQ-013 Ports valid_a and valid_b, output, 1 each: one-cycle pulse marking a new value on d_out_a and d_out_b.
REQ-014 Port clr_req, input, 1: request to zero the whole array.
REQ-015 Port busy, output, 1: high while the clear sequence runs.

Function
REQ-016 Bank select SHALL be addr[ADDR_W-1 -: BANK_BITS]; the in-bank index SHALL be the remaining low bits.
REQ-017 Write: with wr=1 and busy=0, only the bytes of word wr_addr whose be bit is 1 SHALL update at the clock edge.
REQ-018 Read: rd_en_x=1 and busy=0 in cycle N SHALL give d_out_x = mem[rd_addr_x] and valid_x=1 in cycle N+1 (latency 1).
REQ-019 With rd_en_x=0, d_out_x SHALL hold its value and valid_x SHALL be 0.
REQ-020 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-021 FSM states SHALL be CLEAR and IDLE. CLEAR advances to IDLE after the counter hits its last value. IDLE advances to CLEAR on clr_req=1. clr_req is ignored in CLEAR.
REQ-022 In CLEAR, one counter of width ADDR_W-BANK_BITS SHALL zero that index in all banks each cycle. A clear SHALL take 2**(ADDR_W-BANK_BITS) cycles (64 at default parameters).
REQ-023 busy SHALL equal (state == CLEAR). While busy=1, wr and rd_en_x SHALL be ignored and valid_x SHALL be 0.
REQ-024 Same-cycle write and read to the same address: behaviour SHALL follow REQ-031 and REQ-032.

Reset
REQ-025 Asserting reset SHALL immediately force the following, including mid-clear:
- state = CLEAR
- clear counter = 0
- d_out_a = d_out_b = 0
- valid_a = valid_b = 0
- busy = 1
REQ-026 Array contents SHALL NOT be reset directly; they are zeroed by the CLEAR sequence that follows reset deassertion.

Configuration
REQ-027 Macro RAM_BANKED_BYPASS_EN compiles write-to-read forwarding in or out.
REQ-031 With RAM_BANKED_BYPASS_EN defined, a read of the address being written in the same cycle SHALL return the byte-merged new word.
REQ-032 With RAM_BANKED_BYPASS_EN undefined, a read of the address being written in the same cycle SHALL return the old word.

Structure
REQ-028 Shared package ram_pkg SHALL hold:
- default constants DATA_W_DEF, ADDR_W_DEF, BANK_BITS_DEF
- the FSM state typedef (CLEAR, IDLE)
REQ-029 A sub-module ram_bank SHALL implement one bank: one write port with byte enables and two asynchronous read ports. ram_banked SHALL instantiate 2**BANK_BITS copies via generate, plus the bank-select decode and the output mux and registers.

Verification
REQ-030 The bench SHALL cover the following scenarios:
- Reset release -> busy=1 for exactly 64 cycles; then busy=0; reads of addresses 0, 63, 64 and 511 return 0x0000.
- Write 0xBEEF to 0x1A5 with be=2'b11, then read on A and B next cycle -> both ports show 0xBEEF with valid=1 one cycle after rd_en.
- Write 0x1234 to 0x010, then write 0xAB00 with be=2'b10 -> read returns 0xAB34.
- Same-cycle write 0x5555 and read A at 0x0FF (old value 0x1111) -> 0x5555 with RAM_BANKED_BYPASS_EN, 0x1111 without.
- clr_req pulse in IDLE, then wr and rd_en asserted during busy -> no write; valid stays 0; contents zero after busy falls.
- Reset asserted 10 cycles into a clear -> outputs 0 immediately; clear restarts at index 0 and runs a full 64 cycles.
